// File: rtl/ima_adpcm_pkg.sv
// Shared IMA ADPCM constants, tables and arithmetic helpers.
// Used by both the encoder and the matching decoder.
package ima_adpcm_pkg;

  localparam int STEP_INDEX_MAX = 88;
  localparam int PRED_W         = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B2,
    ST_B1,
    ST_B0,
    ST_UPD,
    ST_LKUP
  } enc_state_t;

  localparam logic [14:0] STEP_TABLE [0:88] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  function automatic logic [14:0] step_table(input logic [6:0] idx);
    if (idx > 7'(STEP_INDEX_MAX)) return STEP_TABLE[STEP_INDEX_MAX];
    return STEP_TABLE[idx];
  endfunction

  function automatic logic signed [4:0] index_delta(input logic [2:0] mag);
    case (mag)
      3'd4:    return 5'sd2;
      3'd5:    return 5'sd4;
      3'd6:    return 5'sd6;
      3'd7:    return 5'sd8;
      default: return -5'sd1;
    endcase
  endfunction

  function automatic logic [6:0] step_index_next(input logic [6:0] idx, input logic [2:0] mag);
    logic signed [8:0] sum;
    sum = $signed({2'b00, idx}) + index_delta(mag);
    if (sum < 0) return 7'd0;
    if (sum > STEP_INDEX_MAX) return 7'(STEP_INDEX_MAX);
    return sum[6:0];
  endfunction

  // Sum is kept one bit wider than the 20-bit difference so a full-scale
  // predictor plus a maximum dequant can never wrap before saturation.
  function automatic logic [PRED_W-1:0] pred_sat(input logic [PRED_W+1:0] v);
    if (!v[PRED_W+1] && (v[PRED_W:PRED_W-1] != 2'b00)) return 19'h3FFFF;
    if (v[PRED_W+1] && (v[PRED_W:PRED_W-1] != 2'b11)) return 19'h40000;
    return v[PRED_W-1:0];
  endfunction

  function automatic logic [15:0] pred_round(input logic [PRED_W-1:0] p);
    logic [16:0] r;
    r = {p[18], p[18:3]} + {16'd0, p[2]};
    if (!r[16] && r[15]) return 16'h7FFF;
    return r[15:0];
  endfunction

endpackage

// File: rtl/ima_adpcm_step_rom.sv
// Registered step-index to step-size lookup; updates only when lookup_en is high.
module ima_adpcm_step_rom
  import ima_adpcm_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        lookup_en,
  input  logic [6:0]  step_index,
  output logic [14:0] step_size
);

  logic [14:0] rom [0:STEP_INDEX_MAX];
  logic [14:0] step_size_q;
  logic [14:0] step_size_d;

  generate
    for (genvar gi = 0; gi <= STEP_INDEX_MAX; gi++) begin : g_rom
      assign rom[gi] = step_table(7'(gi));
    end
  endgenerate

  always_comb begin
    step_size_d = step_size_q;
    if (lookup_en) begin
      step_size_d = (step_index > 7'(STEP_INDEX_MAX)) ? rom[STEP_INDEX_MAX] : rom[step_index];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) step_size_q <= 15'd7;
    else        step_size_q <= step_size_d;
  end

  assign step_size = step_size_q;

endmodule

// File: rtl/ima_adpcm_enc.sv
// IMA ADPCM encoder: successive-approximation quantiser producing one
// magnitude bit per cycle while tracking the decoder's predictor/step index.
module ima_adpcm_enc
  import ima_adpcm_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] inSamp,
  input  logic        inValid,
  output logic        inReady,
  input  logic [15:0] inPredictSamp,
  input  logic [6:0]  inStepIndex,
  input  logic        inStateLoad,
  output logic [3:0]  outPCM,
  output logic        outValid,
  output logic [15:0] outPredictSamp,
  output logic [6:0]  outStepIndex
);

  enc_state_t        state_q, state_d;
  logic [PRED_W-1:0] pred_q, pred_d;
  logic [6:0]        idx_q, idx_d;
  logic              sign_q, sign_d;
  logic [19:0]       mag_q, mag_d;
  logic [2:0]        bits_q, bits_d;
  logic [3:0]        pcm_q, pcm_d;
  logic              valid_q, valid_d;

  logic [14:0] step_size;
  logic [19:0] step_ext;
  logic [19:0] diff;
  logic [19:0] trial;
  logic [19:0] dequant;
  logic [20:0] pred_ext;
  logic [20:0] pre_sum;
  logic [1:0]  shamt;
  logic [2:0]  bit_mask;

  ima_adpcm_step_rom u_step_rom (
    .clock      (clock),
    .reset      (reset),
    .lookup_en  (state_q == ST_LKUP),
    .step_index (idx_q),
    .step_size  (step_size)
  );

  assign step_ext = {5'd0, step_size};
  assign diff     = {inSamp[15], inSamp, 3'b000} - {pred_q[18], pred_q};
  assign dequant  = (bits_q[2] ? (step_ext << 3) : 20'd0)
                  + (bits_q[1] ? (step_ext << 2) : 20'd0)
                  + (bits_q[0] ? (step_ext << 1) : 20'd0)
                  + step_ext;
  assign pred_ext = {{2{pred_q[18]}}, pred_q};
  assign pre_sum  = sign_q ? (pred_ext - {1'b0, dequant}) : (pred_ext + {1'b0, dequant});

  always_comb begin
    state_d  = state_q;
    pred_d   = pred_q;
    idx_d    = idx_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    bits_d   = bits_q;
    pcm_d    = pcm_q;
    valid_d  = 1'b0;
    shamt    = 2'd3;
    bit_mask = 3'b100;
    trial    = 20'd0;

    case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          sign_d  = diff[19];
          mag_d   = diff[19] ? (20'd0 - diff) : diff;
          bits_d  = 3'b000;
          state_d = ST_B2;
        end
      end
      ST_B2, ST_B1, ST_B0: begin
        if (state_q == ST_B1) begin
          shamt    = 2'd2;
          bit_mask = 3'b010;
        end else if (state_q == ST_B0) begin
          shamt    = 2'd1;
          bit_mask = 3'b001;
        end
        trial = step_ext << shamt;
        if (mag_q >= trial) begin
          mag_d  = mag_q - trial;
          bits_d = bits_q | bit_mask;
        end
        state_d = (state_q == ST_B2) ? ST_B1 : (state_q == ST_B1) ? ST_B0 : ST_UPD;
      end
      ST_UPD: begin
        pred_d  = pred_sat(pre_sum);
        idx_d   = step_index_next(idx_q, bits_q);
        pcm_d   = {sign_q, bits_q};
        valid_d = 1'b1;
        state_d = ST_LKUP;
      end
      ST_LKUP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A state load aborts any sample in flight; LKUP refreshes the step size.
    if (inStateLoad) begin
      pred_d  = {inPredictSamp, 3'b000};
      idx_d   = (inStepIndex > 7'(STEP_INDEX_MAX)) ? 7'(STEP_INDEX_MAX) : inStepIndex;
      valid_d = 1'b0;
      state_d = ST_LKUP;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pred_q  <= '0;
      idx_q   <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bits_q  <= '0;
      pcm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pred_q  <= pred_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bits_q  <= bits_d;
      pcm_q   <= pcm_d;
      valid_q <= valid_d;
    end
  end

  assign inReady        = reset && (state_q == ST_IDLE);
  assign outPCM         = pcm_q;
  assign outValid       = valid_q;
  assign outPredictSamp = pred_round(pred_q);
  assign outStepIndex   = idx_q;

endmodule

// File: tb/tb_ima_adpcm_enc.sv
// Scoreboard bench for ima_adpcm_enc: an integer IMA reference model predicts
// each nibble and the post-update header values.
module tb_ima_adpcm_enc;

  logic        clock;
  logic        reset;
  logic [15:0] inSamp;
  logic        inValid;
  logic        inReady;
  logic [15:0] inPredictSamp;
  logic [6:0]  inStepIndex;
  logic        inStateLoad;
  logic [3:0]  outPCM;
  logic        outValid;
  logic [15:0] outPredictSamp;
  logic [6:0]  outStepIndex;

  ima_adpcm_enc dut (
    .clock          (clock),
    .reset          (reset),
    .inSamp         (inSamp),
    .inValid        (inValid),
    .inReady        (inReady),
    .inPredictSamp  (inPredictSamp),
    .inStepIndex    (inStepIndex),
    .inStateLoad    (inStateLoad),
    .outPCM         (outPCM),
    .outValid       (outValid),
    .outPredictSamp (outPredictSamp),
    .outStepIndex   (outStepIndex)
  );

  localparam int STEP_TBL [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
    3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442,
    11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794,
    32767
  };
  localparam int IDX_ADJ [0:7] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  typedef struct {
    logic [3:0]  pcm;
    logic [15:0] samp;
    logic [6:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   m_pred   = 0;
  int   m_idx    = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference IMA encoder step in 16.3 fixed point using plain integers.
  function automatic void model_push(input logic [15:0] s);
    int   diff, mag, step, code, vp, p, r;
    bit   sgn;
    exp_t e;
    diff = int'($signed(s)) * 8 - m_pred;
    sgn  = (diff < 0);
    mag  = sgn ? -diff : diff;
    step = STEP_TBL[m_idx];
    code = 0;
    vp   = step;
    if (mag >= step * 8) begin code += 4; mag -= step * 8; vp += step * 8; end
    if (mag >= step * 4) begin code += 2; mag -= step * 4; vp += step * 4; end
    if (mag >= step * 2) begin code += 1; vp += step * 2; end
    p = sgn ? m_pred - vp : m_pred + vp;
    if (p > 262143) p = 262143;
    if (p < -262144) p = -262144;
    m_pred = p;
    m_idx  = m_idx + IDX_ADJ[code];
    if (m_idx < 0) m_idx = 0;
    if (m_idx > 88) m_idx = 88;
    r = (p >>> 3) + ((p >> 2) & 1);
    if (r > 32767) r = 32767;
    e.pcm  = {sgn, 3'(code)};
    e.samp = 16'(r);
    e.idx  = 7'(m_idx);
    sb.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (reset === 1'b1 && outValid === 1'b1) begin
      exp_t e;
      n_out++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: outValid=1 with no pending sample (outPCM=%h)", outPCM);
      end else begin
        e = sb.pop_front();
        if (outPCM !== e.pcm || outPredictSamp !== e.samp || outStepIndex !== e.idx) begin
          n_fail++;
          $display("FAIL nibble: got pcm=%h pred=%h idx=%0d, expected pcm=%h pred=%h idx=%0d",
                   outPCM, outPredictSamp, outStepIndex, e.pcm, e.samp, e.idx);
        end else begin
          $display("out  pcm=%h pred=%h idx=%0d", outPCM, outPredictSamp, outStepIndex);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; inValid = 1'b0; inStateLoad = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (inReady !== 1'b0 || outValid !== 1'b0 || outPCM !== 4'h0 ||
        outPredictSamp !== 16'h0000 || outStepIndex !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_state: inReady=%b outValid=%b pcm=%h pred=%h idx=%0d, expected 0 0 0 0000 0",
               inReady, outValid, outPCM, outPredictSamp, outStepIndex);
    end
    reset = 1'b1;
    sb.delete();
    m_pred = 0;
    m_idx  = 0;
  endtask

  task automatic send(input logic [15:0] s, input bit hold);
    bit ok = 0;
    @(negedge clock);
    inSamp  = s;
    inValid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (t > 0) @(negedge clock);
      if (inReady === 1'b1) begin
        acc_cyc = cyc;
        model_push(s);
        ok = 1;
        @(posedge clock);
        #1;
        if (!hold) inValid = 1'b0;
        $display("in   samp=%h cyc=%0d", s, acc_cyc);
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      inValid = 1'b0;
      $display("FAIL accept_timeout: inReady=%b, expected 1 within 40 cycles", inReady);
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clock);
      if (sb.size() == 0 && inReady === 1'b1) ok = 1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: pending=%0d inReady=%b, expected 0 pending and ready", sb.size(), inReady);
    end
  endtask

  task automatic check_hdr(input string name, input logic [3:0] pcm, input logic [15:0] ps, input logic [6:0] idx);
    n_checks++;
    if (outPCM !== pcm || outPredictSamp !== ps || outStepIndex !== idx) begin
      n_fail++;
      $display("FAIL %s: got pcm=%h pred=%h idx=%0d, expected pcm=%h pred=%h idx=%0d",
               name, outPCM, outPredictSamp, outStepIndex, pcm, ps, idx);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    n_checks++;
    if (inReady !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: inReady=%b, expected 1", inReady);
    end
  endtask

  task automatic test_zero();
    do_reset();
    send(16'h0000, 0);
    wait_done();
    check_hdr("zero_sample", 4'h0, 16'h0001, 7'd0);
  endtask

  task automatic test_pos();
    do_reset();
    send(16'h0100, 0);
    wait_done();
    check_hdr("pos_sample", 4'h7, 16'd13, 7'd8);
    send(16'h0100, 0);
    wait_done();
  endtask

  task automatic test_neg();
    do_reset();
    send(16'hFF00, 0);
    wait_done();
    check_hdr("neg_sample", 4'hF, 16'hFFF3, 7'd8);
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clock);
    inStateLoad = 1'b1; inPredictSamp = 16'h7FF0; inStepIndex = 7'd88;
    @(negedge clock);
    inStateLoad = 1'b0;
    m_pred = 16'h7FF0 * 8;
    m_idx  = 88;
    send(16'h7FFF, 0);
    wait_done();
    check_hdr("saturate", 4'h0, 16'h7FFF, 7'd87);
  endtask

  task automatic test_abort();
    int v0;
    do_reset();
    @(negedge clock);
    inSamp = 16'h1234; inValid = 1'b1;
    @(posedge clock);
    #1 inValid = 1'b0;
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    inStateLoad = 1'b1; inPredictSamp = 16'hC000; inStepIndex = 7'd100;
    v0 = n_out;
    @(negedge clock);
    inStateLoad = 1'b0;
    n_checks++;
    if (inReady !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: inReady=%b, expected 0 one cycle after load", inReady);
    end
    @(negedge clock);
    n_checks++;
    if (inReady !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: inReady=%b, expected 1 two cycles after load", inReady);
    end
    check_hdr("abort_load", outPCM, 16'hC000, 7'd88);
    repeat (6) @(negedge clock);
    n_checks++;
    if (n_out != v0) begin
      n_fail++;
      $display("FAIL abort_no_nibble: %0d nibbles emitted, expected 0", n_out - v0);
    end
    m_pred = int'($signed(16'hC000)) * 8;
    m_idx  = 88;
    send(16'h4000, 0);
    wait_done();
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    int prev;
    do_reset();
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 20)      s = 16'(-32768 + i * 3449);
      else if (i < 24) s = 16'h7000;
      else if (i < 28) s = 16'h9000;
      else if (i < 32) s = 16'h0000;
      else             s = 16'(32767 - (i - 32) * 8191);
      send(s, 1);
      if (i > 0) begin
        n_checks++;
        if (acc_cyc - prev != 6) begin
          n_fail++;
          $display("FAIL accept_spacing: sample %0d accepted %0d cycles after previous, expected 6",
                   i, acc_cyc - prev);
        end
      end
      prev = acc_cyc;
    end
    inValid = 1'b0;
    wait_done();
  endtask

  initial begin
    reset = 1'b0; inValid = 1'b0; inSamp = '0;
    inStateLoad = 1'b0; inPredictSamp = '0; inStepIndex = '0;
    test_reset();
    test_zero();
    test_pos();
    test_neg();
    test_saturate();
    test_abort();
    test_back_to_back();
    repeat (4) @(negedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected nibbles never produced, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
